can_rec_arbiter: RTL and testbench
==================================

Name: can_rec_arbiter

Overview:
- Round-robin scheduler sharing the single uplink path (CAN receive -> e-link) among up to 32 CAN buses on MOPSHUB.
- Watches per-bus receive-pending flags, selects one bus, drives can_rec_select, issues a start pulse to the uplink datapath and holds the selection until the datapath acknowledges or times out.
- Sits between the 32 CAN controllers and the uplink packer inside mopshub_top.

Parameters:
- TIMEOUT_CYCLES, 4096, cycles in WAIT_ACK before abandoning a grant; minimum 2.
- GAP_CYCLES, 2, idle cycles inserted after each grant before the next search; 0 allowed.

Ports:
- clk  in  1  system clock, 40 MHz.
- rst  in  1  asynchronous reset, active-high.
- enable  in  1  arbitration enable.
- n_buses  in  5  highest eligible bus index; buses 0..n_buses take part, higher indices are ignored.
- irq_can_rec  in  32  per-bus receive-pending flags, level.
- rec_done  in  1  one-cycle acknowledge from the uplink datapath: message taken.
- can_rec_select  out  5  granted bus index.
- rec_start  out  1  one-cycle pulse: uplink must fetch from can_rec_select.
- busy  out  1  high in every state except IDLE.
- timeout_err  out  1  one-cycle pulse on grant timeout.

Behaviour:
- Reset values:
  - can_rec_select=0, rec_start=0, busy=0, timeout_err=0.
  - Internal search pointer start_idx=0, state IDLE, counters 0.
- Eligible request vector: req = irq_can_rec AND mask(bits 0..n_buses).
- Search: first set bit of req scanning start_idx, start_idx+1, ..., n_buses, then wrapping to 0..start_idx-1.
  - If start_idx > n_buses (n_buses lowered at runtime), the scan starts at 0.
- States:
  - IDLE: if enable=1 and req!=0, go to GRANT next cycle and register the winner into can_rec_select. Otherwise stay.
  - GRANT (1 cycle): rec_start=1, busy=1, then go to WAIT_ACK with the timeout counter cleared.
  - WAIT_ACK: can_rec_select held stable; counter increments each cycle.
    - rec_done=1: go to GAP; start_idx = grant+1 (wraps to 0 when grant = n_buses or grant = 31).
    - Counter reaches TIMEOUT_CYCLES-1 without rec_done: timeout_err pulses 1 cycle; start_idx advances exactly as on rec_done; go to GAP.
    - rec_done in the same cycle as expiry: counts as done, no timeout_err.
  - GAP: wait GAP_CYCLES cycles, then go to IDLE. With GAP_CYCLES=0, pass straight to IDLE in one cycle.
- Latency: req asserted in IDLE -> can_rec_select valid next edge -> rec_start the following cycle. That is 2 cycles from request to start pulse.
- rec_done outside WAIT_ACK is ignored.
- A request dropping during WAIT_ACK does not abort the grant; the block waits for done or timeout.
- enable deasserted mid-transaction: the current grant completes normally (including GAP), then the block stays in IDLE.
- irq changes and n_buses changes take effect only at the IDLE search.
- can_rec_select keeps its last value in IDLE; it is meaningful only while busy=1.
- Fairness: a continuously requesting bus is granted at most once per full rotation while other eligible buses request.
- rst asserted at any time returns every output and register to its reset value immediately, independent of the clock.

Optional Feature:
- Macro CAN_REC_ARB_STATS_EN.
- When defined, adds:
  - input stats_clr (1): synchronous clear, wins over increments.
  - output grant_cnt (16): saturating count of rec_start pulses.
  - output timeout_cnt (8): saturating count of timeout_err pulses.
  - Both counters reset to 0.
- When undefined: these ports and logic do not exist; arbitration behaviour is identical.

Test Plan:
- Reset mid-WAIT_ACK: grant bus 3, assert rst asynchronously -> all outputs 0 at once; after release, first grant goes to the lowest requesting index.
- n_buses=1, irq_can_rec=32'h0000_0003, rec_done 3 cycles after each rec_start -> grants alternate 0,1,0,1; rec_start 2 cycles after req; GAP_CYCLES=2 idle cycles between grants.
- n_buses=4, irq_can_rec=32'h8000_0010 -> only bus 4 granted, bus 31 never selected.
- TIMEOUT_CYCLES=8, bus 5 requesting, rec_done never given -> timeout_err pulses 8 cycles after WAIT_ACK entry; next grant searches from bus 6.
- rec_done on the same cycle as timeout expiry -> no timeout_err; pointer advances.
- With CAN_REC_ARB_STATS_EN: 3 completed grants plus 1 timeout -> grant_cnt=4, timeout_cnt=1; stats_clr -> both 0 next cycle.

Source files
------------

// File: rtl/can_rec_arbiter.sv
// ---------------------------------------------------------------------------
// can_rec_arbiter
// Round-robin scheduler for the shared CAN-receive -> e-link uplink path.
// It watches the per-bus receive-pending flags of up to 32 CAN buses, picks
// one, presents its index on can_rec_select and pulses rec_start. The
// selection is held until the uplink acknowledges with rec_done or the grant
// times out. A short gap follows each grant before the next search.
//
// Optional build macro: CAN_REC_ARB_STATS_EN adds saturating grant/timeout
// counters with a synchronous clear.
// ---------------------------------------------------------------------------
module can_rec_arbiter #(
    parameter int TIMEOUT_CYCLES = 4096,  // minimum 2
    parameter int GAP_CYCLES     = 2      // 0 allowed
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [4:0]  n_buses,
    input  logic [31:0] irq_can_rec,
    input  logic        rec_done,
`ifdef CAN_REC_ARB_STATS_EN
    input  logic        stats_clr,
    output logic [15:0] grant_cnt,
    output logic [7:0]  timeout_cnt,
`endif
    output logic [4:0]  can_rec_select,
    output logic        rec_start,
    output logic        busy,
    output logic        timeout_err
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [GW-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : GW'(0);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_GRANT    = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_GAP      = 2'd3
    } state_t;

    state_t          r_state;
    logic [4:0]      r_sel;
    logic [4:0]      r_start_idx;
    logic [TW-1:0]   r_to_cnt;
    logic [GW-1:0]   r_gap_cnt;
    logic            r_rec_start;
    logic            r_busy;
    logic            r_timeout_err;

    logic [31:0]     w_mask;
    logic [31:0]     w_req;
    logic [4:0]      w_base;
    logic            w_found;
    logic [4:0]      w_winner;
    logic [4:0]      w_next_ptr;
    logic            w_expired;

    // Eligibility mask, rotating first-set search and next-pointer computation.
    // Bits above n_buses are masked, so a plain modulo-32 scan from the base
    // visits base..n_buses and then wraps to 0..base-1 as required.
    always_comb begin
        logic [4:0] v_idx;
        v_idx    = 5'd0;
        w_found  = 1'b0;
        w_winner = 5'd0;
        for (int i = 0; i < 32; i++) begin
            w_mask[i] = (5'(i) <= n_buses);
        end
        w_req  = irq_can_rec & w_mask;
        w_base = (r_start_idx > n_buses) ? 5'd0 : r_start_idx;
        for (int i = 0; i < 32; i++) begin
            v_idx = w_base + 5'(i);
            if (!w_found && w_req[v_idx]) begin
                w_found  = 1'b1;
                w_winner = v_idx;
            end else begin
                w_found  = w_found;
            end
        end
        if ((r_sel == n_buses) || (r_sel == 5'd31)) begin
            w_next_ptr = 5'd0;
        end else begin
            w_next_ptr = r_sel + 5'd1;
        end
        w_expired = (r_to_cnt == TO_LAST);
    end

    // Arbitration FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_sel         <= 5'd0;
            r_start_idx   <= 5'd0;
            r_to_cnt      <= {TW{1'b0}};
            r_gap_cnt     <= {GW{1'b0}};
            r_rec_start   <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_rec_start   <= 1'b0;
                    r_timeout_err <= 1'b0;
                    if (enable && w_found) begin
                        r_sel   <= w_winner;
                        r_busy  <= 1'b1;
                        r_state <= ST_GRANT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_GRANT: begin
                    r_rec_start   <= 1'b1;
                    r_busy        <= 1'b1;
                    r_timeout_err <= 1'b0;
                    r_to_cnt      <= {TW{1'b0}};
                    r_state       <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    r_rec_start <= 1'b0;
                    r_busy      <= 1'b1;
                    if (rec_done) begin
                        // done wins over a simultaneous expiry
                        r_timeout_err <= 1'b0;
                        r_start_idx   <= w_next_ptr;
                        r_gap_cnt     <= {GW{1'b0}};
                        r_state       <= ST_GAP;
                    end else if (w_expired) begin
                        r_timeout_err <= 1'b1;
                        r_start_idx   <= w_next_ptr;
                        r_gap_cnt     <= {GW{1'b0}};
                        r_state       <= ST_GAP;
                    end else begin
                        r_timeout_err <= 1'b0;
                        r_to_cnt      <= r_to_cnt + {{(TW-1){1'b0}}, 1'b1};
                        r_state       <= ST_WAIT_ACK;
                    end
                end
                ST_GAP: begin
                    r_rec_start   <= 1'b0;
                    r_timeout_err <= 1'b0;
                    if ((GAP_CYCLES == 0) || (r_gap_cnt == GAP_LAST)) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_busy    <= 1'b1;
                        r_gap_cnt <= r_gap_cnt + {{(GW-1){1'b0}}, 1'b1};
                        r_state   <= ST_GAP;
                    end
                end
                default: begin
                    r_rec_start   <= 1'b0;
                    r_busy        <= 1'b0;
                    r_timeout_err <= 1'b0;
                    r_state       <= ST_IDLE;
                end
            endcase
        end
    end

    assign can_rec_select = r_sel;
    assign rec_start      = r_rec_start;
    assign busy           = r_busy;
    assign timeout_err    = r_timeout_err;

`ifdef CAN_REC_ARB_STATS_EN
    logic [15:0] r_grant_cnt;
    logic [7:0]  r_timeout_cnt;

    // Saturating statistics counters; clear has priority over counting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant_cnt   <= 16'd0;
            r_timeout_cnt <= 8'd0;
        end else if (stats_clr) begin
            r_grant_cnt   <= 16'd0;
            r_timeout_cnt <= 8'd0;
        end else begin
            // a rec_start pulse is launched on every GRANT exit
            if ((r_state == ST_GRANT) && (r_grant_cnt != 16'hFFFF)) begin
                r_grant_cnt <= r_grant_cnt + 16'd1;
            end else begin
                r_grant_cnt <= r_grant_cnt;
            end
            if ((r_state == ST_WAIT_ACK) && !rec_done && w_expired &&
                (r_timeout_cnt != 8'hFF)) begin
                r_timeout_cnt <= r_timeout_cnt + 8'd1;
            end else begin
                r_timeout_cnt <= r_timeout_cnt;
            end
        end
    end

    assign grant_cnt   = r_grant_cnt;
    assign timeout_cnt = r_timeout_cnt;
`endif

endmodule

// File: tb/tb_can_rec_arbiter.sv
// ---------------------------------------------------------------------------
// Directed self-checking bench for can_rec_arbiter (TIMEOUT_CYCLES=8,
// GAP_CYCLES=2). Inputs change and outputs are sampled 1 ns after the rising
// edge.
// ---------------------------------------------------------------------------
module tb_can_rec_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [4:0]  n_buses;
    logic [31:0] irq_can_rec;
    logic        rec_done;
    logic [4:0]  can_rec_select;
    logic        rec_start;
    logic        busy;
    logic        timeout_err;
`ifdef CAN_REC_ARB_STATS_EN
    logic        stats_clr;
    logic [15:0] grant_cnt;
    logic [7:0]  timeout_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    can_rec_arbiter #(.TIMEOUT_CYCLES(8), .GAP_CYCLES(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .n_buses        (n_buses),
        .irq_can_rec    (irq_can_rec),
        .rec_done       (rec_done),
`ifdef CAN_REC_ARB_STATS_EN
        .stats_clr      (stats_clr),
        .grant_cnt      (grant_cnt),
        .timeout_cnt    (timeout_cnt),
`endif
        .can_rec_select (can_rec_select),
        .rec_start      (rec_start),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // wait (bounded) for a rec_start pulse and check the granted index
    task automatic wait_start(input string tag, input logic [4:0] exp_sel);
        int n;
        n = 0;
        while (rec_start !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_start_seen"}, {31'd0, rec_start}, 32'd1);
        chk({tag, "_sel"}, {27'd0, can_rec_select}, {27'd0, exp_sel});
    endtask

    // acknowledge 3 cycles after the rec_start pulse
    task automatic finish_done();
        tick();
        tick();
        rec_done = 1'b1;
        tick();
        rec_done = 1'b0;
    endtask

    task automatic serve(input string tag, input logic [4:0] exp_sel);
        wait_start(tag, exp_sel);
        finish_done();
    endtask

    initial begin
        rst         = 1'b1;
        enable      = 1'b0;
        n_buses     = 5'd0;
        irq_can_rec = 32'd0;
        rec_done    = 1'b0;
`ifdef CAN_REC_ARB_STATS_EN
        stats_clr   = 1'b0;
`endif
        tick();
        tick();
        chk("rst_sel",   {27'd0, can_rec_select}, 32'd0);
        chk("rst_start", {31'd0, rec_start}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_to",    {31'd0, timeout_err}, 32'd0);
        rst = 1'b0;
        tick();

        // two buses alternate, check latency and gap on the first grant
        n_buses     = 5'd1;
        irq_can_rec = 32'h0000_0003;
        enable      = 1'b1;
        tick();
        chk("a_sel_1st",   {27'd0, can_rec_select}, 32'd0);
        chk("a_busy_1st",  {31'd0, busy}, 32'd1);
        chk("a_start_1st", {31'd0, rec_start}, 32'd0);
        tick();
        chk("a_start_2cyc", {31'd0, rec_start}, 32'd1);
        finish_done();
        chk("a_gap_busy0", {31'd0, busy}, 32'd1);
        tick();
        chk("a_gap_busy1", {31'd0, busy}, 32'd1);
        tick();
        chk("a_idle_busy", {31'd0, busy}, 32'd0);
        chk("a_idle_hold", {27'd0, can_rec_select}, 32'd0);
        tick();
        chk("a_reg_sel1", {27'd0, can_rec_select}, 32'd1);
        tick();
        chk("a_start_g1", {31'd0, rec_start}, 32'd1);
        finish_done();
        serve("a_g2", 5'd0);
        serve("a_g3", 5'd1);

        // masked high bus never wins
        n_buses     = 5'd4;
        irq_can_rec = 32'h8000_0010;
        serve("c_g0", 5'd4);
        serve("c_g1", 5'd4);

        // enable low: pending request and stray rec_done ignored
        enable = 1'b0;
        repeat (6) tick();
        rec_done = 1'b1;
        tick();
        rec_done = 1'b0;
        repeat (3) tick();
        chk("e_busy",  {31'd0, busy}, 32'd0);
        chk("e_start", {31'd0, rec_start}, 32'd0);
        chk("e_to",    {31'd0, timeout_err}, 32'd0);
        enable = 1'b1;

        // timeout on bus 5, then search resumes at 6
        n_buses     = 5'd7;
        irq_can_rec = 32'h0000_0020;
        wait_start("d_g0", 5'd5);
        irq_can_rec = 32'h0000_0000;  // dropped request does not abort grant
        repeat (7) tick();
        chk("d_to_early", {31'd0, timeout_err}, 32'd0);
        chk("d_sel_hold", {27'd0, can_rec_select}, 32'd5);
        tick();
        chk("d_to_pulse", {31'd0, timeout_err}, 32'd1);
        chk("d_to_busy",  {31'd0, busy}, 32'd1);
        tick();
        chk("d_to_1cyc",  {31'd0, timeout_err}, 32'd0);
        irq_can_rec = 32'h0000_00A4;
        serve("d_g1", 5'd7);

        // done exactly at expiry: no error, pointer still advances
        irq_can_rec = 32'h0000_0020;
        wait_start("t_g0", 5'd5);
        repeat (7) tick();
        rec_done = 1'b1;
        tick();
        rec_done = 1'b0;
        chk("t_no_to0", {31'd0, timeout_err}, 32'd0);
        tick();
        chk("t_no_to1", {31'd0, timeout_err}, 32'd0);
        irq_can_rec = 32'h0000_0060;
        serve("t_g1", 5'd6);

        // asynchronous reset in the middle of WAIT_ACK
        irq_can_rec = 32'h0000_0008;
        wait_start("r_g0", 5'd3);
        tick();
        #3;
        rst = 1'b1;
        #1;
        chk("r_async_sel",   {27'd0, can_rec_select}, 32'd0);
        chk("r_async_busy",  {31'd0, busy}, 32'd0);
        chk("r_async_start", {31'd0, rec_start}, 32'd0);
        chk("r_async_to",    {31'd0, timeout_err}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        irq_can_rec = 32'h0000_0048;
        serve("r_g1", 5'd3);

`ifdef CAN_REC_ARB_STATS_EN
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        chk("s_clr0_g", {16'd0, grant_cnt}, 32'd0);
        chk("s_clr0_t", {24'd0, timeout_cnt}, 32'd0);
        irq_can_rec = 32'h0000_0002;
        serve("s_g0", 5'd1);
        serve("s_g1", 5'd1);
        serve("s_g2", 5'd1);
        wait_start("s_g3", 5'd1);
        repeat (8) tick();
        chk("s_to_pulse", {31'd0, timeout_err}, 32'd1);
        chk("s_grant4",   {16'd0, grant_cnt}, 32'd4);
        chk("s_timeout1", {24'd0, timeout_cnt}, 32'd1);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        chk("s_clr1_g", {16'd0, grant_cnt}, 32'd0);
        chk("s_clr1_t", {24'd0, timeout_cnt}, 32'd0);
`endif

        repeat (4) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
